branch_predictor: RTL

Dynamic branch predictor for the 5-stage core. It holds a direct-mapped table that combines a branch target buffer with 2-bit saturating counters. In IF it supplies a taken/target prediction for the fetch PC; this prediction drives `branch_predicted_i` of the hazard unit and the next-PC mux. In EX it receives the resolved outcome, trains the table, and raises a misprediction/redirect that the hazard unit turns into IF/ID and ID/EX flushes.

---
 rtl/branch_predictor.sv | 103 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational IF lookup,
// registered EX training, misprediction/redirect generation and perf counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_if,
  output logic        o_pred_taken_if,
  output logic [31:0] o_pred_target_if,
  input  logic        i_upd_valid_ex,
  input  logic [31:0] i_upd_pc_ex,
  input  logic        i_upd_taken_ex,
  input  logic [31:0] i_upd_target_ex,
  input  logic        i_pred_taken_ex,
  input  logic [31:0] i_pred_target_ex,
  output logic        o_mispredict_ex,
  output logic [31:0] o_redirect_pc_ex,
  output logic [31:0] o_perf_branches,
  output logic [31:0] o_perf_mispred
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [29:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [31:0]      r_perf_branches;
  logic [31:0]      r_perf_mispred;

  logic [IDX_W-1:0] w_idx_if;
  logic [TAG_W-1:0] w_tag_if;
  logic             w_hit_if;
  logic [IDX_W-1:0] w_idx_upd;
  logic [TAG_W-1:0] w_tag_upd;
  logic             w_hit_upd;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic             w_mispredict;

  // Lookup path: purely combinational, sees committed state only (no bypass).
  assign w_idx_if = i_pc_if[IDX_W+1:2];
  assign w_tag_if = i_pc_if[31:IDX_W+2];
  assign w_hit_if = r_valid[w_idx_if] && (r_tag[w_idx_if] == w_tag_if);

  assign o_pred_taken_if  = w_hit_if && r_ctr[w_idx_if][1];
  assign o_pred_target_if = o_pred_taken_if ? {r_target[w_idx_if], 2'b00} : 32'd0;

  assign w_idx_upd = i_upd_pc_ex[IDX_W+1:2];
  assign w_tag_upd = i_upd_pc_ex[31:IDX_W+2];
  assign w_hit_upd = r_valid[w_idx_upd] && (r_tag[w_idx_upd] == w_tag_upd);
  assign w_ctr_cur = r_ctr[w_idx_upd];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (i_upd_taken_ex) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
    end
  end

  assign w_mispredict = i_upd_valid_ex &&
                        ((i_pred_taken_ex != i_upd_taken_ex) ||
                         (i_upd_taken_ex && (i_pred_target_ex != i_upd_target_ex)));

  assign o_mispredict_ex  = w_mispredict;
  assign o_redirect_pc_ex = i_upd_taken_ex ? i_upd_target_ex : (i_upd_pc_ex + 32'd4);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_perf_branches <= 32'd0;
      r_perf_mispred  <= 32'd0;
    end else begin
      if (i_upd_valid_ex) begin
        r_perf_branches <= r_perf_branches + 32'd1;
        if (w_hit_upd) begin
          r_ctr[w_idx_upd] <= w_ctr_next;
          if (i_upd_taken_ex) r_target[w_idx_upd] <= i_upd_target_ex[31:2];
        end else if (i_upd_taken_ex) begin
          // Allocation on a taken miss evicts whatever aliases into this slot.
          r_valid[w_idx_upd]  <= 1'b1;
          r_tag[w_idx_upd]    <= w_tag_upd;
          r_target[w_idx_upd] <= i_upd_target_ex[31:2];
          r_ctr[w_idx_upd]    <= 2'b10;
        end
      end
      if (w_mispredict) r_perf_mispred <= r_perf_mispred + 32'd1;
    end
  end

  assign o_perf_branches = r_perf_branches;
  assign o_perf_mispred  = r_perf_mispred;

endmodule
